// File: rtl/mem_txn_tracker.sv
// Generic FIFO: extra pointer bit tells full from empty; no write-to-read bypass.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: push is refused only when full with no pop in the same cycle; pop on empty is ignored.
module mem_txn_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok     = pop_i && !empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok    = push_i && (!full_o || pop_ok);
    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; wraps naturally modulo 2*DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing is read past the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
endmodule

// Tracks data-memory ops from decode through grant to in-order response, emitting timestamped records.
// Latency: rvalid at cycle N gives rec_valid at N+1; a marker gives repeat_detected at N+1.
// Backpressure: rec_ready low holds the head record; completions into a full record FIFO are dropped and flagged.
module mem_txn_tracker #(
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int TAG_WIDTH       = 8,
    parameter int INSTR_DEPTH     = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int OUT_DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                counter,
    input  logic                       enable,
    input  logic                       instr_valid,
    input  logic                       instr_is_mem,
    input  logic                       instr_marker,
    input  logic [TAG_WIDTH-1:0]       instr_tag,
    input  logic                       data_mem_req,
    input  logic                       data_mem_gnt,
    input  logic                       data_mem_we,
    input  logic                       data_mem_rvalid,
    input  logic [DATA_ADDR_WIDTH-1:0] data_mem_addr,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [TAG_WIDTH-1:0]       rec_tag,
    output logic [DATA_ADDR_WIDTH-1:0] rec_addr,
    output logic                       rec_we,
    output logic [31:0]                rec_start,
    output logic [31:0]                rec_end,
    output logic                       repeat_detected,
    output logic                       err_overflow,
    output logic                       err_orphan_gnt,
    output logic                       err_spurious_rvalid
);
    typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_DRAIN} state_e;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]       tag;
        logic [DATA_ADDR_WIDTH-1:0] addr;
        logic                       we;
        logic [31:0]                start;
    } txn_t;

    typedef struct packed {
        txn_t        txn;
        logic [31:0] stop;
    } rec_t;

    state_e state_q, state_d;
    logic   rep_q, rep_d;
    logic   ovf_q, ovf_d;
    logic   orph_q, orph_d;
    logic   spur_q, spur_d;

    logic                 ins_full, ins_empty;
    logic                 ost_full, ost_empty;
    logic                 rec_full, rec_empty;
    logic [TAG_WIDTH-1:0] ins_head;
    txn_t                 ost_in, ost_head;
    rec_t                 rec_in, rec_head, rec_out;

    logic active, grant, grant_ok, rsp, ost_pop, rec_pop, ins_push;

    // Bus activity is only tracked outside IDLE; IDLE always has empty FIFOs.
    assign active   = (state_q != ST_IDLE);
    assign grant    = active && data_mem_req && data_mem_gnt;
    assign rsp      = active && data_mem_rvalid;
    assign rec_pop  = !rec_empty && rec_ready;
    // Emptiness is judged at cycle start, so a same-cycle grant never answers this rvalid.
    assign ost_pop  = rsp && !ost_empty;
    assign grant_ok = grant && !ins_empty && (!ost_full || ost_pop);
    assign ins_push = (state_q == ST_TRACK) && instr_valid && instr_is_mem && !instr_marker;

    assign ost_in.tag   = ins_head;
    assign ost_in.addr  = data_mem_addr;
    assign ost_in.we    = data_mem_we;
    assign ost_in.start = counter;
    assign rec_in.txn   = ost_head;
    assign rec_in.stop  = counter;

    mem_txn_fifo #(.WIDTH(TAG_WIDTH), .DEPTH(INSTR_DEPTH)) u_ins_fifo (
        .clk(clk), .rst_n(rst_n),
        .push_i(ins_push), .push_dat_i(instr_tag), .pop_i(grant_ok),
        .head_dat_o(ins_head), .full_o(ins_full), .empty_o(ins_empty)
    );

    mem_txn_fifo #(.WIDTH($bits(txn_t)), .DEPTH(MAX_OUTSTANDING)) u_ost_fifo (
        .clk(clk), .rst_n(rst_n),
        .push_i(grant_ok), .push_dat_i(ost_in), .pop_i(ost_pop),
        .head_dat_o(ost_head), .full_o(ost_full), .empty_o(ost_empty)
    );

    mem_txn_fifo #(.WIDTH($bits(rec_t)), .DEPTH(OUT_DEPTH)) u_rec_fifo (
        .clk(clk), .rst_n(rst_n),
        .push_i(ost_pop), .push_dat_i(rec_in), .pop_i(rec_pop),
        .head_dat_o(rec_head), .full_o(rec_full), .empty_o(rec_empty)
    );

    // Fields read as zero whenever no record is presented.
    assign rec_out   = rec_empty ? '0 : rec_head;
    assign rec_valid = !rec_empty;
    assign rec_tag   = rec_out.txn.tag;
    assign rec_addr  = rec_out.txn.addr;
    assign rec_we    = rec_out.txn.we;
    assign rec_start = rec_out.txn.start;
    assign rec_end   = rec_out.stop;

    assign repeat_detected     = rep_q;
    assign err_overflow        = ovf_q;
    assign err_orphan_gnt      = orph_q;
    assign err_spurious_rvalid = spur_q;

    // Mode sequencing: DRAIN finishes queued work before dropping to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (enable) state_d = ST_TRACK;
            ST_TRACK: if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable)                       state_d = ST_TRACK;
                else if (ins_empty && ost_empty)  state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Marker pulse and sticky error accumulation.
    always_comb begin
        rep_d  = active && instr_valid && instr_marker;
        ovf_d  = ovf_q
               || (ins_push && ins_full && !grant_ok)
               || (ost_pop && rec_full && !rec_pop);
        orph_d = orph_q || (grant && !grant_ok);
        spur_d = spur_q || (rsp && ost_empty);
    end

    // State, pulse and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rep_q   <= 1'b0;
            ovf_q   <= 1'b0;
            orph_q  <= 1'b0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            ovf_q   <= ovf_d;
            orph_q  <= orph_d;
            spur_q  <= spur_d;
        end
    end
endmodule

// File: tb/tb_mem_txn_tracker.sv
// Self-checking bench for mem_txn_tracker: vector table, directed corner sequences, random vs queue model.
// Latency: outputs sampled 1 ns after each rising edge; inputs change at the same point.
// Backpressure: rec_ready is driven both by the vectors and randomly, including long stalls.
module tb_mem_txn_tracker;
    localparam int IDEPTH = 8;
    localparam int MAXO   = 4;
    localparam int OUTD   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] counter = '0;
    logic        enable = 1'b0;
    logic        instr_valid = 1'b0, instr_is_mem = 1'b0, instr_marker = 1'b0;
    logic [7:0]  instr_tag = '0;
    logic        data_mem_req = 1'b0, data_mem_gnt = 1'b0, data_mem_we = 1'b0, data_mem_rvalid = 1'b0;
    logic [31:0] data_mem_addr = '0;
    logic        rec_valid, rec_ready = 1'b0;
    logic [7:0]  rec_tag;
    logic [31:0] rec_addr, rec_start, rec_end;
    logic        rec_we;
    logic        repeat_detected, err_overflow, err_orphan_gnt, err_spurious_rvalid;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    mem_txn_tracker #(
        .DATA_ADDR_WIDTH(32), .TAG_WIDTH(8), .INSTR_DEPTH(IDEPTH),
        .MAX_OUTSTANDING(MAXO), .OUT_DEPTH(OUTD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .counter(counter), .enable(enable),
        .instr_valid(instr_valid), .instr_is_mem(instr_is_mem), .instr_marker(instr_marker),
        .instr_tag(instr_tag), .data_mem_req(data_mem_req), .data_mem_gnt(data_mem_gnt),
        .data_mem_we(data_mem_we), .data_mem_rvalid(data_mem_rvalid), .data_mem_addr(data_mem_addr),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_tag(rec_tag), .rec_addr(rec_addr),
        .rec_we(rec_we), .rec_start(rec_start), .rec_end(rec_end),
        .repeat_detected(repeat_detected), .err_overflow(err_overflow),
        .err_orphan_gnt(err_orphan_gnt), .err_spurious_rvalid(err_spurious_rvalid)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit en, input bit iv, input bit im, input bit imk, input logic [7:0] tag,
                         input bit gr, input logic [31:0] addr, input bit we, input bit rv, input bit rdy,
                         input logic [31:0] cnt);
        enable = en; instr_valid = iv; instr_is_mem = im; instr_marker = imk; instr_tag = tag;
        data_mem_req = gr; data_mem_gnt = gr; data_mem_addr = addr; data_mem_we = we;
        data_mem_rvalid = rv; rec_ready = rdy; counter = cnt;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit en, iv, im, imk; logic [7:0] tag; bit gr; logic [31:0] addr; bit we, rv, rdy; logic [31:0] cnt;
        bit e_vld; logic [7:0] e_tag; logic [31:0] e_addr; bit e_we; logic [31:0] e_st, e_en; bit e_rep;
    } vec_t;

    function automatic vec_t v(bit en, bit iv, bit im, bit imk, logic [7:0] tag, bit gr, logic [31:0] addr,
                               bit we, bit rv, bit rdy, logic [31:0] cnt, bit e_vld, logic [7:0] e_tag,
                               logic [31:0] e_addr, bit e_we, logic [31:0] e_st, logic [31:0] e_en, bit e_rep);
        vec_t r;
        r.en = en; r.iv = iv; r.im = im; r.imk = imk; r.tag = tag; r.gr = gr; r.addr = addr; r.we = we;
        r.rv = rv; r.rdy = rdy; r.cnt = cnt; r.e_vld = e_vld; r.e_tag = e_tag; r.e_addr = e_addr;
        r.e_we = e_we; r.e_st = e_st; r.e_en = e_en; r.e_rep = e_rep;
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] tag; logic [31:0] addr; logic we; logic [31:0] st; logic [31:0] en;
    } mrec_t;

    int         m_state;        // 0 idle, 1 tracking, 2 draining
    logic [7:0] m_ins[$];
    mrec_t      m_out[$];
    mrec_t      m_rec[$];
    bit         m_rep, m_eov, m_eor, m_esp;

    task automatic model_reset();
        m_state = 0; m_ins.delete(); m_out.delete(); m_rec.delete();
        m_rep = 0; m_eov = 0; m_eor = 0; m_esp = 0;
    endtask

    // One clock of behaviour: departures leave the queues before arrivals join them.
    task automatic model_step();
        bit    act;
        int    ns;
        mrec_t o;
        act = (m_state != 0);
        ns  = m_state;
        if (m_state == 0 && enable) ns = 1;
        else if (m_state == 1 && !enable) ns = 2;
        else if (m_state == 2) begin
            if (enable) ns = 1;
            else if (m_ins.size() == 0 && m_out.size() == 0) ns = 0;
        end
        m_rep = act && instr_valid && instr_marker;
        if (m_rec.size() > 0 && rec_ready) void'(m_rec.pop_front());
        if (act && data_mem_rvalid) begin
            if (m_out.size() == 0) m_esp = 1;
            else begin
                o = m_out.pop_front();
                o.en = counter;
                if (m_rec.size() < OUTD) m_rec.push_back(o);
                else m_eov = 1;
            end
        end
        if (act && data_mem_req && data_mem_gnt) begin
            if (m_ins.size() > 0 && m_out.size() < MAXO) begin
                o.tag = m_ins.pop_front(); o.addr = data_mem_addr; o.we = data_mem_we;
                o.st = counter; o.en = 0;
                m_out.push_back(o);
            end else m_eor = 1;
        end
        if (m_state == 1 && instr_valid && instr_is_mem && !instr_marker) begin
            if (m_ins.size() < IDEPTH) m_ins.push_back(instr_tag);
            else m_eov = 1;
        end
        m_state = ns;
    endtask

    initial begin
        vec_t vt[$];

        // ---------------- reset state ----------------
        do_reset();
        chk("reset_rec_valid", rec_valid, 0);
        chk("reset_rec_fields", {rec_tag, rec_addr, rec_we, rec_start, rec_end}, 0);
        chk("reset_flags", {repeat_detected, err_overflow, err_orphan_gnt, err_spurious_rvalid}, 0);

        // ---------------- table: single txn, in-order triple, marker ----------------
        vt.push_back(v(1,0,0,0,8'h00, 0,32'h0,0, 0,0,  1, 0,0,0,0,0,0,0));
        vt.push_back(v(1,1,1,0,8'h05, 0,32'h0,0, 0,0,  2, 0,0,0,0,0,0,0));
        vt.push_back(v(1,0,0,0,8'h00, 1,32'h1000,0, 0,0,100, 0,0,0,0,0,0,0));
        vt.push_back(v(1,0,0,0,8'h00, 0,32'h0,0, 0,0,101, 0,0,0,0,0,0,0));
        vt.push_back(v(1,0,0,0,8'h00, 0,32'h0,0, 0,0,102, 0,0,0,0,0,0,0));
        vt.push_back(v(1,0,0,0,8'h00, 0,32'h0,0, 1,0,103, 1,8'h05,32'h1000,0,100,103,0));
        vt.push_back(v(1,0,0,0,8'h00, 0,32'h0,0, 0,1,104, 0,0,0,0,0,0,0));
        vt.push_back(v(1,1,1,0,8'h01, 0,32'h0,0, 0,0,  7, 0,0,0,0,0,0,0));
        vt.push_back(v(1,1,1,0,8'h02, 0,32'h0,0, 0,0,  8, 0,0,0,0,0,0,0));
        vt.push_back(v(1,1,1,0,8'h03, 0,32'h0,0, 0,0,  9, 0,0,0,0,0,0,0));
        vt.push_back(v(1,0,0,0,8'h00, 1,32'h10,1, 0,0, 10, 0,0,0,0,0,0,0));
        vt.push_back(v(1,0,0,0,8'h00, 1,32'h20,0, 0,0, 11, 0,0,0,0,0,0,0));
        vt.push_back(v(1,0,0,0,8'h00, 1,32'h30,1, 0,0, 12, 0,0,0,0,0,0,0));
        vt.push_back(v(1,0,0,0,8'h00, 0,32'h0,0, 0,0, 13, 0,0,0,0,0,0,0));
        vt.push_back(v(1,0,0,0,8'h00, 0,32'h0,0, 1,1, 14, 1,8'h01,32'h10,1,10,14,0));
        vt.push_back(v(1,0,0,0,8'h00, 0,32'h0,0, 1,1, 15, 1,8'h02,32'h20,0,11,15,0));
        vt.push_back(v(1,0,0,0,8'h00, 0,32'h0,0, 1,1, 16, 1,8'h03,32'h30,1,12,16,0));
        vt.push_back(v(1,0,0,0,8'h00, 0,32'h0,0, 0,1, 17, 0,0,0,0,0,0,0));
        vt.push_back(v(1,1,1,1,8'h77, 0,32'h0,0, 0,0, 18, 0,0,0,0,0,0,1));
        vt.push_back(v(1,0,0,0,8'h00, 0,32'h0,0, 0,0, 19, 0,0,0,0,0,0,0));
        vt.push_back(v(1,1,0,0,8'h99, 0,32'h0,0, 0,0, 20, 0,0,0,0,0,0,0));

        foreach (vt[i]) begin
            drive(vt[i].en, vt[i].iv, vt[i].im, vt[i].imk, vt[i].tag, vt[i].gr, vt[i].addr,
                  vt[i].we, vt[i].rv, vt[i].rdy, vt[i].cnt);
            cyc();
            chk($sformatf("vec%0d_rec_valid", i), rec_valid, vt[i].e_vld);
            chk($sformatf("vec%0d_repeat", i), repeat_detected, vt[i].e_rep);
            if (vt[i].e_vld)
                chk($sformatf("vec%0d_record", i), {rec_tag, rec_addr, rec_we, rec_start, rec_end},
                    {vt[i].e_tag, vt[i].e_addr, vt[i].e_we, vt[i].e_st, vt[i].e_en});
        end
        chk("vec_errors_clear", {err_overflow, err_orphan_gnt, err_spurious_rvalid}, 0);

        // ---------------- orphan grant, spurious rvalid ----------------
        // Marker and non-mem rows above must have left the instruction FIFO empty.
        drive(1, 0, 0, 0, 0, 1, 32'h44, 0, 0, 0, 30);
        cyc();
        chk("orphan_flag", err_orphan_gnt, 1);
        chk("orphan_no_spur", err_spurious_rvalid, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 31);
        cyc();
        chk("spur_flag", err_spurious_rvalid, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32);
        cyc();
        chk("spur_no_record", rec_valid, 0);
        chk("spur_no_overflow", err_overflow, 0);

        // ---------------- record FIFO overflow with rec_ready low ----------------
        for (int i = 0; i < OUTD + 1; i++) begin
            drive(1, 1, 1, 0, 8'hA0 + 8'(i), 0, 0, 0, 0, 0, 200 + i); cyc();
        end
        for (int i = 0; i < OUTD; i++) begin
            drive(1, 0, 0, 0, 0, 1, 32'h100 * i, i[0], 0, 0, 210 + i); cyc();
        end
        for (int i = 0; i < OUTD; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 220 + i); cyc();
        end
        chk("full_no_overflow_yet", err_overflow, 0);
        drive(1, 0, 0, 0, 0, 1, 32'hBEEF, 1, 0, 0, 230); cyc();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 231); cyc();
        chk("ovf_flag", err_overflow, 1);
        for (int i = 0; i < OUTD; i++) begin
            chk($sformatf("ovf_held%0d", i), {rec_valid, rec_tag, rec_addr, rec_we, rec_start, rec_end},
                {1'b1, 8'hA0 + 8'(i), 32'h100 * i, i[0], 32'(210 + i), 32'(220 + i)});
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 240 + i); cyc();
        end
        chk("ovf_last_dropped", rec_valid, 0);

        // ---------------- drain with two outstanding ----------------
        drive(1, 1, 1, 0, 8'hC1, 0, 0, 0, 0, 1, 298); cyc();
        drive(1, 1, 1, 0, 8'hC2, 0, 0, 0, 0, 1, 299); cyc();
        drive(1, 0, 0, 0, 0, 1, 32'hC100, 0, 0, 1, 300); cyc();
        drive(1, 0, 0, 0, 0, 1, 32'hC200, 1, 0, 1, 301); cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 302); cyc();
        drive(0, 1, 1, 1, 8'h55, 0, 0, 0, 0, 1, 303); cyc();
        chk("drain_marker_pulse", repeat_detected, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 304); cyc();
        chk("drain_rec1", {rec_valid, rec_tag, rec_addr, rec_we, rec_start, rec_end},
            {1'b1, 8'hC1, 32'hC100, 1'b0, 32'd300, 32'd304});
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 305); cyc();
        chk("drain_rec2", {rec_valid, rec_tag, rec_addr, rec_we, rec_start, rec_end},
            {1'b1, 8'hC2, 32'hC200, 1'b1, 32'd301, 32'd305});
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 306); cyc();
        chk("drain_empty", rec_valid, 0);
        drive(0, 1, 1, 1, 8'h56, 0, 0, 0, 0, 1, 307); cyc();
        chk("idle_marker_ignored", repeat_detected, 0);

        // ---------------- reset mid-transaction ----------------
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 400); cyc();
        drive(1, 1, 1, 0, 8'hD1, 0, 0, 0, 0, 0, 401); cyc();
        drive(1, 1, 1, 0, 8'hD2, 1, 32'hD100, 0, 0, 0, 402); cyc();
        drive(1, 0, 0, 0, 0, 1, 32'hD200, 0, 0, 0, 403); cyc();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 404); cyc();
        chk("pre_reset_rec", {rec_valid, rec_tag}, {1'b1, 8'hD1});
        rst_n = 1'b0;
        #1;
        chk("async_reset_rec_valid", rec_valid, 0);
        chk("async_reset_fields", {rec_tag, rec_addr, rec_we, rec_start, rec_end}, 0);
        chk("async_reset_flags", {repeat_detected, err_overflow, err_orphan_gnt, err_spurious_rvalid}, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 405); cyc();
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 406); cyc();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 407); cyc();
        chk("post_reset_no_record", rec_valid, 0);
        chk("post_reset_spurious", err_spurious_rvalid, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 408); cyc();
        chk("post_reset_still_empty", rec_valid, 0);

        // ---------------- randomized run against the queue model ----------------
        do_reset();
        model_reset();
        enable = 1'b1;
        counter = 32'hFFFF_FE00;
        for (int c = 0; c < 3000; c++) begin
            bit g;
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            instr_valid  = ($urandom_range(0, 9) < 5);
            instr_is_mem = ($urandom_range(0, 9) < 8);
            instr_marker = ($urandom_range(0, 19) == 0);
            instr_tag    = 8'($urandom);
            g = (m_ins.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 199) == 0);
            data_mem_req  = g || ($urandom_range(0, 9) == 0);
            data_mem_gnt  = g;
            data_mem_addr = $urandom;
            data_mem_we   = 1'($urandom);
            data_mem_rvalid = (m_out.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 199) == 0);
            rec_ready = ((c / 250) % 2 == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
            counter = counter + 32'd1 + 32'($urandom_range(0, 2));
            model_step();
            cyc();
            chk("rand_rec_valid", rec_valid, m_rec.size() > 0);
            if (m_rec.size() > 0)
                chk("rand_record", {rec_tag, rec_addr, rec_we, rec_start, rec_end}, m_rec[0]);
            chk("rand_repeat", repeat_detected, m_rep);
            chk("rand_errors", {err_overflow, err_orphan_gnt, err_spurious_rvalid}, {m_eov, m_eor, m_esp});
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/mem_txn_tracker.md
MEM_TXN_TRACKER -- requirements
Module: mem_txn_tracker

Interface
REQ-001 Parameter DATA_ADDR_WIDTH, default 32: width of data memory address.
REQ-002 Parameter TAG_WIDTH, default 8: width of instruction tag carried into each record.
REQ-003 Parameter INSTR_DEPTH, default 8 (power of 2): pending mem-instruction FIFO depth.
REQ-004 Parameter MAX_OUTSTANDING, default 4 (power of 2): granted-but-unanswered transaction FIFO depth.
REQ-005 Parameter OUT_DEPTH, default 4 (power of 2): completed-record FIFO depth.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 counter  in  32  free-running cycle count used for timestamps.
REQ-009 enable  in  1  1 = track; 0 = drain outstanding work, then idle.
REQ-010 instr_valid / instr_is_mem / instr_marker  in  1 each  decoded-instruction strobe, mem-op flag, repeat-marker flag.
REQ-011 instr_tag  in  TAG_WIDTH  instruction identifier.
REQ-012 data_mem_req / data_mem_gnt / data_mem_we / data_mem_rvalid  in  1 each  data bus handshake.
REQ-013 data_mem_addr  in  DATA_ADDR_WIDTH  request address.
REQ-014 rec_valid  out  1; rec_ready  in  1  completed-record handshake.
REQ-015 rec_tag, rec_addr, rec_we, rec_start(32), rec_end(32)  out  record fields.
REQ-016 repeat_detected  out  1  one-cycle pulse per marker.
REQ-017 err_overflow, err_orphan_gnt, err_spurious_rvalid  out  1 each  sticky error flags.

Function
REQ-018 FSM states IDLE, TRACK, DRAIN; IDLE->TRACK when enable=1; TRACK->DRAIN when enable=0; DRAIN->IDLE when instruction and outstanding FIFOs both empty; DRAIN->TRACK when enable=1.
REQ-019 In TRACK, instr_valid&instr_is_mem&!instr_marker pushes instr_tag into instruction FIFO; non-mem instructions are ignored.
REQ-020 instr_valid&instr_marker (any state but IDLE) pulses repeat_detected next cycle and pushes nothing.
REQ-021 In IDLE and DRAIN new instructions are dropped without error.
REQ-022 Grant = data_mem_req&data_mem_gnt in one cycle; on grant, head of instruction FIFO pops and {tag, addr, we, start=counter} pushes into outstanding FIFO in the same cycle.
REQ-023 Grant with instruction FIFO empty or outstanding FIFO full: no push, err_orphan_gnt set.
REQ-024 data_mem_rvalid pops oldest outstanding entry (in-order responses) and pushes {entry, end=counter} into record FIFO.
REQ-025 rvalid with outstanding FIFO empty at cycle start sets err_spurious_rvalid; an rvalid never matches a grant of the same cycle.
REQ-026 rvalid with record FIFO full and no simultaneous pop: record dropped, outstanding entry still popped, err_overflow set.
REQ-027 Instruction FIFO full on push: tag dropped, err_overflow set.
REQ-028 Simultaneous push/pop on any FIFO is legal, including full with pop (accepted) and empty with push (no bypass; visible next cycle).
REQ-029 rec_* drive record FIFO head; rec_valid = not empty; pop on rec_valid&rec_ready; fields stable while rec_valid&!rec_ready.
REQ-030 Minimum latency: rvalid at cycle N -> rec_valid at N+1.
REQ-031 Pointers wrap modulo depth with one extra bit for full/empty discrimination.
REQ-032 Timestamps copied unmodified; rec_end < rec_start (counter wrap) passed through unchanged.
REQ-033 Error flags clear only on reset.

Reset
REQ-034 rst_n low asynchronously: state IDLE, all FIFOs empty, rec_valid=0, rec_* fields 0, repeat_detected=0, error flags 0.
REQ-035 Reset mid-transaction discards all pending and outstanding entries; no record emitted for them after release.

Verification
REQ-036 enable=1, mem instr tag 0x05; grant at counter=100 addr 0x1000 we=0; rvalid at 103 -> next cycle rec_valid=1, tag 0x05, addr 0x1000, start 100, end 103.
REQ-037 Three tags 1,2,3, grants at 10,11,12, rvalids at 14,15,16, rec_ready=1 -> records in order 1,2,3 with (10,14),(11,15),(12,16).
REQ-038 rec_ready=0, OUT_DEPTH+1 completions -> first OUT_DEPTH records held intact, err_overflow=1, last dropped.
REQ-039 rvalid with nothing outstanding -> err_spurious_rvalid=1, no record; grant with empty instruction FIFO -> err_orphan_gnt=1.
REQ-040 Marker instruction -> repeat_detected high exactly one cycle, instruction FIFO count unchanged.
REQ-041 Two outstanding, enable=0 -> DRAIN, both records emitted, then IDLE; rst_n pulse mid-transaction -> all outputs 0 immediately, no record after release.
